// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive bridge: parity modes, receive FSM
// encoding and the payload parity helper.
package uart_pkg;

  localparam logic [1:0] PARITY_NONE = 2'd0;
  localparam logic [1:0] PARITY_ODD  = 2'd1;
  localparam logic [1:0] PARITY_EVEN = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  // Expected parity bit for up to 9 payload bits; zero-extension leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [8:0] data, input logic [1:0] mode);
    logic p;
    p = ^data;
    case (mode)
      PARITY_ODD:  parity_bit = ~p;
      PARITY_EVEN: parity_bit = p;
      default:     parity_bit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_bridge_if.sv
// Write port toward the downstream FIFO: registered data, write strobe and
// the FIFO-full back-pressure.
interface uart_rx_bridge_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] data_in;
  logic                 data_in_write;
  logic                 data_in_full;

  modport master (output data_in, output data_in_write, input data_in_full);
  modport slave  (input data_in, input data_in_write, output data_in_full);
endinterface

// File: rtl/uart_rx_os.sv
// Oversampling UART deserialiser: line synchroniser, receive FSM and
// frame/parity error detection with registered one-cycle result pulses.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic                 rx_wire,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  output logic                 frame_err_o,
  output logic                 parity_err_o
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [1:0]    PAR_MODE  = 2'(PARITY);

  logic [1:0]           sync_q;
  logic                 rx_s;
  logic                 stop_bad_s;
  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 stop_bad_q, stop_bad_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;

  assign rx_s = sync_q[1];

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_wire};
    end
  end

  // Next-state and result logic; state only moves on baud_tick cycles.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    stop_bad_d = stop_bad_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    perr_d     = 1'b0;
    stop_bad_s = stop_bad_q | ~rx_s;
    if (baud_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            state_d = ST_START;
            cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_d   = '0;
            bit_d   = 4'd0;
            state_d = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_DATA: begin
          if (cnt_q == FULL_LAST) begin
            cnt_d   = '0;
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_q == BIT_LAST) begin
              stop_idx_d = 1'b0;
              stop_bad_d = 1'b0;
              state_d    = (PAR_MODE == PARITY_NONE) ? ST_STOP : ST_PARITY;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_PARITY: begin
          if (cnt_q == FULL_LAST) begin
            cnt_d   = '0;
            par_d   = rx_s;
            state_d = ST_STOP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_STOP: begin
          if (cnt_q == FULL_LAST) begin
            cnt_d      = '0;
            stop_bad_d = stop_bad_s;
            if (stop_idx_q == STOP_LAST) begin
              state_d = ST_IDLE;
              data_d  = shift_q;
              // A bad stop bit masks any parity verdict for the same frame.
              if (stop_bad_s) begin
                ferr_d = 1'b1;
              end else if ((PAR_MODE != PARITY_NONE) &&
                           (par_q != parity_bit(9'(shift_q), PAR_MODE))) begin
                perr_d = 1'b1;
              end else begin
                valid_d = 1'b1;
              end
            end else begin
              stop_idx_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Receive state and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= 4'd0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      stop_bad_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      stop_bad_q <= stop_bad_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
    end
  end

  assign rx_data_o    = data_q;
  assign rx_valid_o   = valid_q;
  assign frame_err_o  = ferr_q;
  assign parity_err_o = perr_q;

endmodule

// File: rtl/uart_rx_bridge.sv
// UART receive bridge: deserialised bytes go through a small hold queue and
// are written to a downstream FIFO, with overrun detection and counting.
module uart_rx_bridge
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int HOLD_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             baud_tick,
  input  logic             rx_wire,
  uart_rx_bridge_if.master wr,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun_err,
  output logic [7:0]       overrun_cnt
);

  localparam int AW = $clog2(HOLD_DEPTH);
  typedef logic [AW:0] count_t;
  localparam count_t DEPTH = count_t'(HOLD_DEPTH);

  logic [DATA_BITS-1:0] rx_data_s;
  logic                 rx_valid_s;
  logic [DATA_BITS-1:0] mem_q [HOLD_DEPTH];
  logic [AW-1:0]        rd_q, rd_d;
  logic [AW-1:0]        wr_q, wr_d;
  count_t               count_q, count_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 write_q, write_d;
  logic                 ovr_q, ovr_d;
  logic [7:0]           ovr_cnt_q, ovr_cnt_d;
  logic                 empty_s, full_s, pop_s, take_s, store_s, drop_s;
  logic [DATA_BITS-1:0] head_s;

  uart_rx_os #(
    .DATA_BITS  (DATA_BITS),
    .PARITY     (PARITY),
    .STOP_BITS  (STOP_BITS),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_os (
    .clk          (clk),
    .rst_n        (rst_n),
    .baud_tick    (baud_tick),
    .rx_wire      (rx_wire),
    .rx_data_o    (rx_data_s),
    .rx_valid_o   (rx_valid_s),
    .frame_err_o  (frame_err),
    .parity_err_o (parity_err)
  );

  // Queue control; an empty queue forwards the arriving byte straight to the
  // output register so the write lands two cycles after the stop sample.
  always_comb begin
    empty_s   = (count_q == count_t'(0));
    full_s    = (count_q == DEPTH);
    pop_s     = !wr.data_in_full && (!empty_s || rx_valid_s);
    take_s    = pop_s && !empty_s;
    store_s   = rx_valid_s && !(empty_s && pop_s) && (!full_s || pop_s);
    drop_s    = rx_valid_s && full_s && !pop_s;
    head_s    = empty_s ? rx_data_s : mem_q[rd_q];
    rd_d      = take_s ? rd_q + AW'(1) : rd_q;
    wr_d      = store_s ? wr_q + AW'(1) : wr_q;
    data_d    = pop_s ? head_s : data_q;
    write_d   = pop_s;
    ovr_d     = drop_s;
    ovr_cnt_d = ovr_cnt_q;
    if (drop_s && (ovr_cnt_q != 8'hFF)) begin
      ovr_cnt_d = ovr_cnt_q + 8'd1;
    end else begin
      ovr_cnt_d = ovr_cnt_q;
    end
    case ({store_s, take_s})
      2'b10:   count_d = count_q + count_t'(1);
      2'b01:   count_d = count_q - count_t'(1);
      default: count_d = count_q;
    endcase
  end

  // Queue storage; validity is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (store_s) begin
      mem_q[wr_q] <= rx_data_s;
    end
  end

  // Queue pointers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q      <= '0;
      wr_q      <= '0;
      count_q   <= '0;
      data_q    <= '0;
      write_q   <= 1'b0;
      ovr_q     <= 1'b0;
      ovr_cnt_q <= 8'd0;
    end else begin
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      count_q   <= count_d;
      data_q    <= data_d;
      write_q   <= write_d;
      ovr_q     <= ovr_d;
      ovr_cnt_q <= ovr_cnt_d;
    end
  end

  assign wr.data_in       = data_q;
  assign wr.data_in_write = write_q;
  assign overrun_err      = ovr_q;
  assign overrun_cnt      = ovr_cnt_q;

endmodule
